// File: rtl/bkt_in_vars_pkg.sv
// Shared sat-engine definitions: variable value encodings and backtrack FSM states.
package bkt_in_vars_pkg;

  localparam logic [1:0] VAL_FREE    = 2'b00;
  localparam logic [1:0] VAL_FALSE   = 2'b01;
  localparam logic [1:0] VAL_TRUE    = 2'b10;
  localparam int         IMPLIED_BIT = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SCAN = 2'b01,
    S_DONE = 2'b10
  } bkt_state_e;

  function automatic logic is_free(input logic [1:0] val);
    return (val == VAL_FREE);
  endfunction

endpackage

// File: rtl/bkt_in_vars_if.sv
// Write/backtrack bus between the decision logic (master) and the variable store (slave).
interface bkt_in_vars_if #(
  parameter int NUM       = 8,
  parameter int WIDTH     = 3,
  parameter int WIDTH_LVL = 4
);
  logic                       apply_valid_i;
  logic                       apply_ready_o;
  logic [NUM-1:0]             index_i;
  logic [WIDTH-1:0]           value_i;
  logic [WIDTH_LVL-1:0]       level_i;
  logic                       bkt_start_i;
  logic [WIDTH_LVL-1:0]       bkt_lvl_i;
  logic                       bkt_busy_o;
  logic                       bkt_done_o;
  logic [WIDTH_LVL-1:0]       freed_cnt_o;
  logic                       conflict_o;
  logic [NUM*WIDTH-1:0]       value_o;
  logic [NUM*WIDTH_LVL-1:0]   level_o;

  modport master (
    output apply_valid_i, index_i, value_i, level_i, bkt_start_i, bkt_lvl_i,
    input  apply_ready_o, bkt_busy_o, bkt_done_o, freed_cnt_o, conflict_o, value_o, level_o
  );

  modport slave (
    input  apply_valid_i, index_i, value_i, level_i, bkt_start_i, bkt_lvl_i,
    output apply_ready_o, bkt_busy_o, bkt_done_o, freed_cnt_o, conflict_o, value_o, level_o
  );
endinterface

// File: rtl/bkt_in_vars_var_state_cell.sv
// One variable's value and decision level; clear (backtrack) wins over write.
module var_state_cell #(
  parameter int WIDTH     = 3,
  parameter int WIDTH_LVL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic                 clr_en_i,
  input  logic [WIDTH-1:0]     value_i,
  input  logic [WIDTH_LVL-1:0] level_i,
  output logic [WIDTH-1:0]     value_o,
  output logic [WIDTH_LVL-1:0] level_o
);
  logic [WIDTH-1:0]     value_q, value_d;
  logic [WIDTH_LVL-1:0] level_q, level_d;

  always_comb begin
    value_d = value_q;
    level_d = level_q;
    if (clr_en_i) begin
      value_d = '0;
      level_d = '0;
    end else if (wr_en_i) begin
      value_d = value_i;
      level_d = level_i;
    end else begin
      value_d = value_q;
      level_d = level_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      level_q <= '0;
    end else begin
      value_q <= value_d;
      level_q <= level_d;
    end
  end

  assign value_o = value_q;
  assign level_o = level_q;
endmodule

// File: rtl/bkt_in_vars.sv
// Variable assignment store with conflict detection and a one-variable-per-cycle
// backtrack scan that frees every variable assigned above the target level.
module bkt_in_vars
  import bkt_in_vars_pkg::*;
#(
  parameter int NUM       = 8,
  parameter int WIDTH     = 3,
  parameter int WIDTH_LVL = 4
) (
  input  logic         clk,
  input  logic         rst,
  bkt_in_vars_if.slave bus
);
  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

  bkt_state_e           state_q, state_d;
  logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
  logic [WIDTH_LVL-1:0] bkt_lvl_q, bkt_lvl_d;
  logic [WIDTH_LVL-1:0] freed_q, freed_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 conflict_q, conflict_d;

  logic [NUM-1:0]       onehot_s, wr_en_s, clr_en_s;
  logic                 accept_s, target_busy_s;
  logic [WIDTH-1:0]     cell_val_s [NUM];
  logic [WIDTH_LVL-1:0] cell_lvl_s [NUM];
  logic [NUM*WIDTH-1:0]     val_pack_s;
  logic [NUM*WIDTH_LVL-1:0] lvl_pack_s;

  assign bus.apply_ready_o = (state_q == S_IDLE) & ~bus.bkt_start_i;
  assign accept_s          = bus.apply_valid_i & bus.apply_ready_o;
  // Isolate the lowest set bit so a multi-hot index still writes a single variable.
  assign onehot_s          = bus.index_i & (~bus.index_i + NUM'(1'b1));

  always_comb begin
    target_busy_s = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      target_busy_s = target_busy_s | (onehot_s[i] & ~is_free(cell_val_s[i][1:0]));
    end
    wr_en_s    = (accept_s & ~target_busy_s) ? onehot_s : '0;
    conflict_d = accept_s & target_busy_s;
  end

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    bkt_lvl_d  = bkt_lvl_q;
    freed_d    = freed_q;
    clr_en_s   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.bkt_start_i) begin
          state_d    = S_SCAN;
          scan_idx_d = '0;
          bkt_lvl_d  = bus.bkt_lvl_i;
          freed_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (cell_lvl_s[scan_idx_q] > bkt_lvl_q) begin
          clr_en_s[scan_idx_q] = 1'b1;
          freed_d              = freed_q + WIDTH_LVL'(1);
        end else begin
          freed_d = freed_q;
        end
        if (scan_idx_q == IDX_W'(NUM - 1)) begin
          state_d    = S_DONE;
          scan_idx_d = '0;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SCAN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      scan_idx_q <= '0;
      bkt_lvl_q  <= '0;
      freed_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      bkt_lvl_q  <= bkt_lvl_d;
      freed_q    <= freed_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      conflict_q <= conflict_d;
    end
  end

  for (genvar g = 0; g < NUM; g++) begin : g_cell
    var_state_cell #(
      .WIDTH    (WIDTH),
      .WIDTH_LVL(WIDTH_LVL)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .wr_en_i (wr_en_s[g]),
      .clr_en_i(clr_en_s[g]),
      .value_i (bus.value_i),
      .level_i (bus.level_i),
      .value_o (cell_val_s[g]),
      .level_o (cell_lvl_s[g])
    );
  end

  always_comb begin
    val_pack_s = '0;
    lvl_pack_s = '0;
    for (int i = 0; i < NUM; i++) begin
      val_pack_s[i*WIDTH +: WIDTH]         = cell_val_s[i];
      lvl_pack_s[i*WIDTH_LVL +: WIDTH_LVL] = cell_lvl_s[i];
    end
  end

  assign bus.value_o     = val_pack_s;
  assign bus.level_o     = lvl_pack_s;
  assign bus.bkt_busy_o  = busy_q;
  assign bus.bkt_done_o  = done_q;
  assign bus.freed_cnt_o = freed_q;
  assign bus.conflict_o  = conflict_q;
endmodule

// File: tb/tb_bkt_in_vars.sv
// Directed plus randomized bench for bkt_in_vars against an array-based reference model.
module tb_bkt_in_vars;
  localparam int NUM   = 8;
  localparam int WIDTH = 3;
  localparam int WL    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bkt_in_vars_if #(.NUM(NUM), .WIDTH(WIDTH), .WIDTH_LVL(WL)) bus ();
  bkt_in_vars #(.NUM(NUM), .WIDTH(WIDTH), .WIDTH_LVL(WL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] m_val [NUM];
  logic [WL-1:0]    m_lvl [NUM];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM; i++) begin
      m_val[i] = '0;
      m_lvl[i] = '0;
    end
  endtask

  task automatic check_vars(input string tag);
    logic [NUM*WIDTH-1:0] ev;
    logic [NUM*WL-1:0]    el;
    for (int i = 0; i < NUM; i++) begin
      ev[i*WIDTH +: WIDTH] = m_val[i];
      el[i*WL +: WL]       = m_lvl[i];
    end
    chk({tag, "_values"}, 64'(bus.value_o), 64'(ev));
    chk({tag, "_levels"}, 64'(bus.level_o), 64'(el));
  endtask

  task automatic idle_inputs();
    bus.apply_valid_i = 1'b0;
    bus.index_i       = '0;
    bus.value_i       = '0;
    bus.level_i       = '0;
    bus.bkt_start_i   = 1'b0;
    bus.bkt_lvl_i     = '0;
  endtask

  task automatic check_quiet_reset(input string tag);
    chk({tag, "_values"}, 64'(bus.value_o), 64'd0);
    chk({tag, "_levels"}, 64'(bus.level_o), 64'd0);
    chk({tag, "_busy"}, 64'(bus.bkt_busy_o), 64'd0);
    chk({tag, "_done"}, 64'(bus.bkt_done_o), 64'd0);
    chk({tag, "_freed"}, 64'(bus.freed_cnt_o), 64'd0);
    chk({tag, "_conflict"}, 64'(bus.conflict_o), 64'd0);
    chk({tag, "_ready"}, 64'(bus.apply_ready_o), 64'd1);
  endtask

  // A write goes to the first selected variable if it is free; otherwise it is a conflict.
  task automatic do_write(input string tag, input logic [NUM-1:0] idx,
                          input logic [WIDTH-1:0] v, input logic [WL-1:0] l);
    int   t;
    logic exp_conf;
    bus.apply_valid_i = 1'b1;
    bus.index_i       = idx;
    bus.value_i       = v;
    bus.level_i       = l;
    #1;
    chk({tag, "_ready"}, 64'(bus.apply_ready_o), 64'd1);
    tick();
    bus.apply_valid_i = 1'b0;
    t = -1;
    for (int i = 0; i < NUM; i++) if (idx[i] && t < 0) t = i;
    exp_conf = 1'b0;
    if (t >= 0) begin
      if (m_val[t][1:0] != 2'b00) exp_conf = 1'b1;
      else begin
        m_val[t] = v;
        m_lvl[t] = l;
      end
    end
    chk({tag, "_conflict"}, 64'(bus.conflict_o), 64'(exp_conf));
    check_vars(tag);
  endtask

  task automatic do_bkt(input string tag, input logic [WL-1:0] lv, input logic with_write);
    int          n;
    logic [WL-1:0] exp_freed;
    bus.bkt_start_i = 1'b1;
    bus.bkt_lvl_i   = lv;
    if (with_write) begin
      bus.apply_valid_i = 1'b1;
      bus.index_i       = NUM'(1'b1);
      bus.value_i       = 3'b110;
      bus.level_i       = 4'd1;
    end
    #1;
    chk({tag, "_ready_at_start"}, 64'(bus.apply_ready_o), 64'd0);
    tick();
    bus.bkt_start_i   = 1'b0;
    bus.apply_valid_i = 1'b0;
    chk({tag, "_busy_first"}, 64'(bus.bkt_busy_o), 64'd1);
    chk({tag, "_freed_cleared"}, 64'(bus.freed_cnt_o), 64'd0);
    chk({tag, "_conflict_at_start"}, 64'(bus.conflict_o), 64'd0);
    exp_freed = '0;
    for (int i = 0; i < NUM; i++) begin
      if (m_lvl[i] > lv) begin
        m_val[i] = '0;
        m_lvl[i] = '0;
        exp_freed++;
      end
    end
    n = 1;
    for (int g = 0; g < NUM + 4; g++) begin
      tick();
      if (bus.bkt_busy_o) n++;
      else break;
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(NUM));
    chk({tag, "_done"}, 64'(bus.bkt_done_o), 64'd1);
    chk({tag, "_freed"}, 64'(bus.freed_cnt_o), 64'(exp_freed));
    check_vars(tag);
    tick();
    chk({tag, "_done_pulse_end"}, 64'(bus.bkt_done_o), 64'd0);
    chk({tag, "_busy_after"}, 64'(bus.bkt_busy_o), 64'd0);
    chk({tag, "_freed_hold"}, 64'(bus.freed_cnt_o), 64'(exp_freed));
  endtask

  initial begin
    logic [NUM-1:0]   r_idx;
    logic [WIDTH-1:0] r_val;
    logic [WL-1:0]    r_lvl;

    idle_inputs();
    model_clear();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_quiet_reset("reset");

    do_write("write_var2", 8'b0000_0100, 3'b010, 4'd3);
    chk("var2_value", 64'(bus.value_o[2*WIDTH +: WIDTH]), 64'(3'b010));
    chk("var2_level", 64'(bus.level_o[2*WL +: WL]), 64'd3);
    do_write("rewrite_var2", 8'b0000_0100, 3'b001, 4'd5);
    tick();
    chk("conflict_one_cycle", 64'(bus.conflict_o), 64'd0);

    do_write("multihot", 8'b0011_0000, 3'b101, 4'd6);
    do_write("zero_index", 8'b0000_0000, 3'b001, 4'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check_quiet_reset("reset2");
    for (int i = 0; i < NUM; i++) begin
      do_write("fill", NUM'(1) << i, (i % 2 == 0) ? 3'b001 : 3'b110, WL'(i));
    end
    do_bkt("bkt_lvl4", 4'd4, 1'b0);

    do_bkt("start_with_write", 4'd2, 1'b1);

    do_write("pre_rst_a", 8'b1000_0000, 3'b110, 4'd9);
    do_write("pre_rst_b", 8'b0000_1000, 3'b101, 4'd2);
    bus.bkt_start_i = 1'b1;
    bus.bkt_lvl_i   = 4'd0;
    tick();
    bus.bkt_start_i = 1'b0;
    repeat (4) tick();
    chk("midscan_busy", 64'(bus.bkt_busy_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check_quiet_reset("rst_midscan");

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) < 8) begin
        r_idx = NUM'($urandom);
        if ($urandom_range(0, 1) == 0) r_idx = NUM'(1) << $urandom_range(0, NUM - 1);
        r_val = WIDTH'($urandom);
        r_lvl = WL'($urandom);
        do_write("rand_write", r_idx, r_val, r_lvl);
      end else begin
        do_bkt("rand_bkt", WL'($urandom), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bkt_in_vars.md
BKT_IN_VARS -- requirements
Module: bkt_in_vars

Interface
REQ-001 SHALL have parameter NUM, default 8, number of variables held.
REQ-002 SHALL have parameter WIDTH, default 3, per-variable value width: bit2 implied flag, bits[1:0] 00 free, 01 false, 10 true, 11 reserved.
REQ-003 SHALL have parameter WIDTH_LVL, default 4, decision-level width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port apply_valid_i, input, 1, a decision or implication write is offered.
REQ-007 SHALL have port apply_ready_o, output, 1, write accepted this cycle when high with apply_valid_i.
REQ-008 SHALL have port index_i, input, NUM, one-hot target variable from the decision finder.
REQ-009 SHALL have port value_i, input, WIDTH, value to write.
REQ-010 SHALL have port level_i, input, WIDTH_LVL, level to record with the write.
REQ-011 SHALL have port bkt_start_i, input, 1, start a backtrack.
REQ-012 SHALL have port bkt_lvl_i, input, WIDTH_LVL, backtrack target level.
REQ-013 SHALL have port bkt_busy_o, output, 1, backtrack scan in progress.
REQ-014 SHALL have port bkt_done_o, output, 1, one-cycle pulse at backtrack completion.
REQ-015 SHALL have port freed_cnt_o, output, WIDTH_LVL, variables freed by the last backtrack.
REQ-016 SHALL have port conflict_o, output, 1, one-cycle pulse when a write targets a non-free variable.
REQ-017 SHALL have port value_o, output, NUM*WIDTH, packed variable values, var i at [i*WIDTH +: WIDTH], feeding the decision finder.
REQ-018 SHALL have port level_o, output, NUM*WIDTH_LVL, packed variable levels, same packing.

Function
REQ-019 SHALL implement FSM IDLE -> SCAN on bkt_start_i in IDLE; SCAN -> DONE after the scan of var NUM-1; DONE -> IDLE unconditionally.
REQ-020 SHALL drive apply_ready_o = (state==IDLE) & ~bkt_start_i.
REQ-021 SHALL, on an accepted write, update the target variable at the next edge: value <= value_i, level <= level_i.
REQ-022 SHALL write the lowest set bit of index_i when it is multi-hot, and perform no write and no conflict when it is zero.
REQ-023 SHALL, when the target value[1:0] != 00, leave the variable unchanged and pulse conflict_o in the cycle after acceptance.
REQ-024 SHALL give bkt_start_i priority over apply_valid_i when both are asserted in IDLE; the write is not accepted.
REQ-025 SHALL ignore bkt_start_i outside IDLE.
REQ-026 SHALL latch bkt_lvl_i and clear freed_cnt_o on the start edge.
REQ-027 SHALL scan one variable per cycle, index 0..NUM-1, on edges k+1..k+NUM, where k is the start edge.
REQ-028 SHALL, for each scanned variable with level > latched level, set value <= 0 and level <= 0, and increment freed_cnt_o.
REQ-029 SHALL hold bkt_busy_o high from after edge k through edge k+NUM, and bkt_done_o high for exactly one cycle after edge k+NUM (DONE state).
REQ-030 SHALL hold freed_cnt_o stable from DONE until the next start.
REQ-031 SHALL leave variables with level <= latched level, including free ones, untouched.
REQ-032 SHALL derive value_o and level_o directly from registers, with no combinational path from inputs.

Reset
REQ-033 SHALL, at any edge with rst high, including mid-scan, clear all values and levels to 0, set state IDLE, scan index 0, freed_cnt_o 0, bkt_done_o 0, conflict_o 0, bkt_busy_o 0.

Structure
REQ-034 SHALL take value encodings (FREE=2'b00, FALSE=2'b01, TRUE=2'b10, IMPLIED bit index 2) and the FSM state codes from the shared sat-engine package/header.
REQ-035 SHALL instantiate NUM copies of a sub-module var_state_cell, each holding one variable's value and level with write and clear enables.

Verification
REQ-036 SHALL cover: after reset, write index 8'b0000_0100, value 3'b010, level 3 -> value_o var2=3'b010 and level_o var2=3 next cycle.
REQ-037 SHALL cover: a second write to var2 -> no change and one conflict_o pulse.
REQ-038 SHALL cover: vars 0..7 at levels 0..7, then start with bkt_lvl 4 -> bkt_busy_o high 8 cycles, vars 5..7 freed, freed_cnt_o=3, single bkt_done_o pulse.
REQ-039 SHALL cover: bkt_start_i and apply_valid_i asserted together in IDLE -> apply_ready_o=0, scan starts, no write.
REQ-040 SHALL cover: rst at scan cycle 4 -> all outputs 0 and FSM in IDLE next cycle.
REQ-041 SHALL cover: index_i=8'b0011_0000 -> only var4 written; index_i=0 -> no change and no conflict_o.
